// File: rtl/alu_muldiv.sv
`default_nettype none
// ============================================================================
// Module   : alu_muldiv
// Purpose  : Multi-cycle multiply/divide unit with architectural HI/LO
//            registers. Executes MULT/MULTU/DIV/DIVU one bit per cycle
//            (shift-add multiply, restoring divide), services MTHI/MTLO,
//            and raises busy so the hazard unit can stall the pipeline.
// Ports    : clk    - rising-edge clock
//            rst    - synchronous active-high reset
//            start  - request, sampled only while idle
//            op     - 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 nop
//            a, b   - operands (a also carries MTHI/MTLO data)
//            flush  - abort any in-flight operation
//            busy   - high while an operation is in flight
//            done   - one-cycle pulse when HI/LO take a new result
//            hi, lo - HI / LO registers
// Revision : 1.0 - initial release
// ============================================================================
module alu_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int c_CW = $clog2(WIDTH);
    localparam logic [c_CW-1:0] c_LAST = c_CW'(WIDTH - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_FIX  = 2'd2;

    localparam logic [2:0] c_OP_MULT  = 3'd0;
    localparam logic [2:0] c_OP_MULTU = 3'd1;
    localparam logic [2:0] c_OP_DIV   = 3'd2;
    localparam logic [2:0] c_OP_DIVU  = 3'd3;
    localparam logic [2:0] c_OP_MTHI  = 3'd4;
    localparam logic [2:0] c_OP_MTLO  = 3'd5;

    logic [1:0]         r_state;
    logic [c_CW-1:0]    r_cnt;
    logic               r_done;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    // Multiply: {partial product, remaining multiplier bits}.
    // Divide:   {partial remainder, dividend bits / quotient bits}.
    logic [2*WIDTH-1:0] r_acc;
    // Multiplicand magnitude (multiply) or divisor magnitude (divide).
    logic [WIDTH-1:0]   r_opnd;
    logic               r_is_div;
    logic               r_neg_lo;   // negate product / quotient
    logic               r_neg_hi;   // negate remainder (dividend sign)
    logic               r_divz;
    logic [WIDTH-1:0]   r_raw_a;

    // ------------------------------------------------------------------
    // Operand decode for the accept edge
    // ------------------------------------------------------------------
    logic             w_signed;
    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;

    assign w_signed = (op == c_OP_MULT) || (op == c_OP_DIV);
    assign w_a_neg  = w_signed & a[WIDTH-1];
    assign w_b_neg  = w_signed & b[WIDTH-1];
    // Negating MIN yields MIN, whose unsigned reading is the correct magnitude.
    assign w_a_mag  = w_a_neg ? (-a) : a;
    assign w_b_mag  = w_b_neg ? (-b) : b;

    // ------------------------------------------------------------------
    // One shift-add multiply step
    // ------------------------------------------------------------------
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_next;

    assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_opnd};
    assign w_mul_next = r_acc[0] ? {w_mul_sum, r_acc[WIDTH-1:1]}
                                 : {1'b0, r_acc[2*WIDTH-1:1]};

    // ------------------------------------------------------------------
    // One restoring divide step
    // ------------------------------------------------------------------
    logic [WIDTH:0]     w_div_top;
    logic               w_div_ok;
    logic [WIDTH-1:0]   w_div_diff;
    logic [2*WIDTH-1:0] w_div_next;

    // Remainder shifted left with the next dividend bit brought in.
    assign w_div_top  = r_acc[2*WIDTH-1:WIDTH-1];
    assign w_div_ok   = (w_div_top >= {1'b0, r_opnd});
    // When the subtraction is kept the difference is below the divisor,
    // so the low WIDTH bits hold it exactly.
    assign w_div_diff = w_div_top[WIDTH-1:0] - r_opnd;
    assign w_div_next = w_div_ok ? {w_div_diff, r_acc[WIDTH-2:0], 1'b1}
                                 : {r_acc[2*WIDTH-2:0], 1'b0};

    // ------------------------------------------------------------------
    // Sign correction applied in FIX
    // ------------------------------------------------------------------
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;
    logic [WIDTH-1:0]   w_fix_hi;
    logic [WIDTH-1:0]   w_fix_lo;

    assign w_prod = r_neg_lo ? (-r_acc) : r_acc;
    assign w_quo  = r_neg_lo ? (-r_acc[WIDTH-1:0]) : r_acc[WIDTH-1:0];
    assign w_rem  = r_neg_hi ? (-r_acc[2*WIDTH-1:WIDTH]) : r_acc[2*WIDTH-1:WIDTH];

    always_comb begin
        w_fix_hi = w_prod[2*WIDTH-1:WIDTH];
        w_fix_lo = w_prod[WIDTH-1:0];
        if (r_is_div) begin
            if (r_divz) begin
                // Divide by zero: quotient all ones, HI keeps the raw dividend.
                w_fix_hi = r_raw_a;
                w_fix_lo = '1;
            end else begin
                w_fix_hi = w_rem;
                w_fix_lo = w_quo;
            end
        end
    end

    // ------------------------------------------------------------------
    // Control FSM and architectural registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_IDLE;
            r_cnt    <= '0;
            r_done   <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_acc    <= '0;
            r_opnd   <= '0;
            r_is_div <= 1'b0;
            r_neg_lo <= 1'b0;
            r_neg_hi <= 1'b0;
            r_divz   <= 1'b0;
            r_raw_a  <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (start && !flush) begin
                        case (op)
                            c_OP_MULT, c_OP_MULTU: begin
                                r_acc    <= {{WIDTH{1'b0}}, w_b_mag};
                                r_opnd   <= w_a_mag;
                                r_is_div <= 1'b0;
                                r_neg_lo <= w_a_neg ^ w_b_neg;
                                r_neg_hi <= w_a_neg ^ w_b_neg;
                                r_divz   <= 1'b0;
                                r_raw_a  <= a;
                                r_cnt    <= '0;
                                r_state  <= c_RUN;
                            end
                            c_OP_DIV, c_OP_DIVU: begin
                                r_acc    <= {{WIDTH{1'b0}}, w_a_mag};
                                r_opnd   <= w_b_mag;
                                r_is_div <= 1'b1;
                                r_neg_lo <= w_a_neg ^ w_b_neg;
                                r_neg_hi <= w_a_neg;
                                r_divz   <= (b == '0);
                                r_raw_a  <= a;
                                r_cnt    <= '0;
                                r_state  <= c_RUN;
                            end
                            c_OP_MTHI: r_hi <= a;
                            c_OP_MTLO: r_lo <= a;
                            default: ;
                        endcase
                    end
                end

                c_RUN: begin
                    if (flush) begin
                        r_state <= c_IDLE;
                    end else begin
                        r_acc <= r_is_div ? w_div_next : w_mul_next;
                        r_cnt <= r_cnt + c_CW'(1);
                        if (r_cnt == c_LAST) begin
                            r_state <= c_FIX;
                        end
                    end
                end

                c_FIX: begin
                    r_state <= c_IDLE;
                    if (!flush) begin
                        r_hi   <= w_fix_hi;
                        r_lo   <= w_fix_lo;
                        r_done <= 1'b1;
                    end
                end

                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign busy = (r_state != c_IDLE);
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule
`default_nettype wire

// File: doc/alu_muldiv.md
Name: alu_muldiv

Overview:
Parametrised multi-cycle multiply/divide unit with architectural HI/LO registers. It is the sequential companion to the single-cycle logic ALU in the EX stage. It executes MULT/MULTU/DIV/DIVU iteratively, one bit per cycle. It also services MTHI/MTLO writes and exposes busy so the hazard unit can stall the pipeline.

Parameters:
WIDTH, 32, operand width in bits; legal range WIDTH >= 2; HI and LO are each WIDTH bits.

Ports:
clk  input  1  rising-edge clock
rst  input  1  reset; synchronous, active-high
start  input  1  request; sampled only when busy=0
op  input  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO, 6/7=no action
a  input  WIDTH  multiplicand / dividend / MTHI-MTLO data
b  input  WIDTH  multiplier / divisor
flush  input  1  abort the in-flight operation (exception/eret)
busy  output  1  high while state != IDLE (combinational from state)
done  output  1  one-cycle pulse; HI/LO hold the new result in that cycle
hi  output  WIDTH  HI register (product upper half / remainder)
lo  output  WIDTH  LO register (product lower half / quotient)

Behaviour:
- Reset values: state=IDLE, hi=0, lo=0, done=0, iteration counter=0. Reset overrides start, flush and any in-flight operation; no partial result reaches HI/LO.
- FSM states: IDLE, RUN, FIX.
- Accept: an edge with state=IDLE, start=1 and flush=0 accepts op.
- MTHI/MTLO: on the accept edge, hi<=a or lo<=a. State stays IDLE. No done pulse, busy stays 0.
- op 6/7: ignored. No state change, no register change.
- MULT/MULTU/DIV/DIVU on the accept edge:
  - Latch |a| and |b| (signed ops) or a and b (unsigned ops).
  - Latch the result signs and the operation type.
  - Clear counter; go to RUN.
- RUN: one radix-2 step per cycle; counter increments each cycle. When counter==WIDTH-1, the next edge moves to FIX. RUN lasts exactly WIDTH cycles.
  - Multiply: shift-add over a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract.
- FIX: apply two's-complement sign correction, write hi/lo, set done=1, go to IDLE.
- Latency: if start is accepted at edge E0, new hi/lo and done=1 are visible after edge E0+WIDTH+1. That is WIDTH+2 cycles from the start cycle. busy=1 for WIDTH+1 cycles.
- done is registered and clears on the following edge.
- Multiply result: full 2*WIDTH-bit product; hi=upper WIDTH bits, lo=lower WIDTH bits. A signed product is negated when exactly one operand is negative.
- Divide result: quotient truncates toward zero. Remainder takes the dividend's sign, with |rem| < |b|.
- Divide by zero (b==0, signed or unsigned): lo=all ones, hi=a (raw input value). Full latency; no exception signalled.
- Signed overflow (a=MIN, b=-1): lo=MIN, hi=0, i.e. two's-complement wrap. No flag.
- start while busy=1: ignored; operands and op are not captured.
- flush while busy: the next edge returns to IDLE. hi/lo are unchanged and done stays 0. flush on the FIX cycle also suppresses the write.
- flush and start together in IDLE: flush wins; nothing is accepted, MTHI/MTLO included.
- hi/lo change only on MTHI/MTLO accept, FIX completion, or reset.

Test Plan:
- WIDTH=32, MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; done exactly 33 edges after the accept edge; busy high for 33 cycles.
- MULT a=-3 (0xFFFFFFFD) b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. DIV a=-7 b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=7 b=2 -> lo=3, hi=1.
- DIVU a=7 b=0 -> lo=0xFFFFFFFF, hi=7. DIV a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- MTHI a=0x1234 then MTLO a=0x5678 in consecutive cycles -> hi=0x1234 and lo=0x5678 one edge after each accept; busy and done stay 0.
- Start DIV, then assert flush at RUN cycle 10 -> IDLE next edge; hi/lo keep their prior values; no done. A second start during RUN with different operands is ignored and the first result is unaffected.
- Assert rst mid-RUN -> next edge: busy=0, done=0, hi=lo=0. Also rerun the signed multiply and divide cases with WIDTH=8 against a reference model, 1000 random operands.
